// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: byte-addressed requests to a word memory; sub-word stores run read-modify-write, misaligned accesses split in two.
// Define LSU_MISALIGN_TRAP_EN to reject word-crossing accesses with resp_err instead of splitting them.
module lsu_mem_ctrl #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            req_funct3,
  input  logic                  req_store,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

  localparam logic [DEPTH_LOG2-1:0] WORD_STEP = 1;

  state_t                state, nstate;
  logic [DEPTH_LOG2-1:0] w_q, w_nx;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  st_q;
  logic [31:0]           wd_q, buf0, buf1;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic supported(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [2:0] f3);
    return ({1'b0, off} + size_of(f3)) > 3'd4;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      default: return 8'h0F;
    endcase
  endfunction

  logic req_sup, req_cross, cross_q;
  logic unused_addr_bits;

  assign req_sup          = supported(req_store, req_funct3);
  assign req_cross        = crosses(req_addr[1:0], req_funct3);
  assign cross_q          = crosses(off_q, f3_q);
  assign w_nx             = w_q + WORD_STEP;
  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

  // Load path sees the word being read this cycle so DONE can register it on entry.
  logic [31:0] b0, b1, ld_raw, ld_val;
  assign b0     = (state == RD0) ? mem_rdata : buf0;
  assign b1     = (state == RD1) ? mem_rdata : buf1;
  assign ld_raw = 32'({b1, b0} >> {off_q, 3'b000});

  always_comb begin
    ld_val = ld_raw;
    case (f3_q)
      3'b000:  ld_val = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'b001:  ld_val = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'b100:  ld_val = {24'h0, ld_raw[7:0]};
      3'b101:  ld_val = {16'h0, ld_raw[15:0]};
      default: ld_val = ld_raw;
    endcase
  end

  // Store merge over the little-endian 64-bit window {buf1, buf0}.
  logic [7:0]  lanes;
  logic [63:0] wd_sh, merged;
  assign lanes = lane_mask(f3_q) << off_q;
  assign wd_sh = {32'h0, wd_q} << {off_q, 3'b000};

  always_comb begin
    merged = {buf1, buf0};
    for (int k = 0; k < 8; k++) begin
      if (lanes[k]) merged[8*k +: 8] = wd_sh[8*k +: 8];
    end
  end

  always_comb begin
    nstate    = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_sup) nstate = DONE;
`ifdef LSU_MISALIGN_TRAP_EN
          else if (req_cross) nstate = DONE;
`endif
          else if (req_store && req_funct3 == 3'b010 && req_addr[1:0] == 2'b00) nstate = WR0;
          else nstate = RD0;
        end
      end
      RD0: begin
        mem_addr = w_q;
        if (cross_q)   nstate = RD1;
        else if (st_q) nstate = WR0;
        else           nstate = DONE;
      end
      RD1: begin
        mem_addr = w_nx;
        nstate   = st_q ? WR0 : DONE;
      end
      WR0: begin
        mem_we    = 1'b1;
        mem_addr  = w_q;
        mem_wdata = merged[31:0];
        nstate    = cross_q ? WR1 : DONE;
      end
      WR1: begin
        mem_we    = 1'b1;
        mem_addr  = w_nx;
        mem_wdata = merged[63:32];
        nstate    = DONE;
      end
      DONE: begin
        if (resp_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      w_q        <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      st_q       <= 1'b0;
      wd_q       <= '0;
      buf0       <= '0;
      buf1       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IDLE && req_valid) begin
        w_q   <= req_addr[DEPTH_LOG2+1:2];
        off_q <= req_addr[1:0];
        f3_q  <= req_funct3;
        st_q  <= req_store;
        wd_q  <= req_wdata;
      end
      if (state == RD0) buf0 <= mem_rdata;
      if (state == RD1) buf1 <= mem_rdata;
      // Only IDLE jumps straight to DONE, and only for rejected requests.
      if (nstate == DONE && state != DONE) begin
        resp_err   <= (state == IDLE);
        resp_rdata <= (state == RD0 || state == RD1) ? ld_val : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 32-word memory model and per-cycle memory-port log.
// Define LSU_MISALIGN_TRAP_EN here too when building the trapping variant.
module tb_lsu_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_store;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  lsu_mem_ctrl #(.DEPTH_LOG2(5)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_store(req_store), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge CLK) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_a]     <= pl_d;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  // Per-transaction log; index = cycles after the accept edge.
  int          lat, nwe;
  logic        cyc_we [0:20];
  logic [4:0]  cyc_ad [0:20];
  logic [31:0] cyc_wd [0:20];
  logic [31:0] rsp_d;
  logic        rsp_e;

  // Starts on a negedge with the DUT idle; returns on the negedge after DONE
  // when resp_ready is high, otherwise still inside DONE.
  task automatic xfer(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    chk("req_ready_before", 32'(req_ready), 32'd1);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    lat = 0;
    nwe = 0;
    do begin
      @(negedge CLK);
      req_valid = 1'b0;
      lat++;
      cyc_we[lat] = mem_we;
      cyc_ad[lat] = mem_addr;
      cyc_wd[lat] = mem_wdata;
      if (mem_we) nwe++;
    end while (!resp_valid && lat < 20);
    chk("resp_valid_seen", 32'(resp_valid), 32'd1);
    rsp_d = resp_rdata;
    rsp_e = resp_err;
    if (resp_ready) @(negedge CLK);
  endtask

  initial begin
    RST        = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h08;
    req_wdata  = 32'hDEADBEEF;

    // Reset held with a request pending
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    RST = 1'b1;

    // Aligned SW then LW
    xfer(1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we_n1", 32'(cyc_we[1]), 32'd1);
    chk("sw_addr_n1", 32'(cyc_ad[1]), 32'd2);
    chk("sw_wdata_n1", cyc_wd[1], 32'hDEADBEEF);
    chk("sw_nwe", 32'(nwe), 32'd1);
    chk("sw_rdata", rsp_d, 32'h0);
    chk("sw_err", 32'(rsp_e), 32'd0);
    xfer(1'b0, 3'b010, 32'h08, 32'h0);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rdata", rsp_d, 32'hDEADBEEF);
    chk("lw_nwe", 32'(nwe), 32'd0);

    // SB read-modify-write; upper wdata bytes must be ignored
    xfer(1'b1, 3'b000, 32'h09, 32'h1234567F);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_rd_addr", 32'(cyc_ad[1]), 32'd2);
    chk("sb_we_n2", 32'(cyc_we[2]), 32'd1);
    chk("sb_wdata_n2", cyc_wd[2], 32'hDEAD7FEF);
    chk("sb_nwe", 32'(nwe), 32'd1);
    xfer(1'b0, 3'b000, 32'h09, 32'h0);
    chk("lb_09", rsp_d, 32'h0000007F);
    xfer(1'b0, 3'b000, 32'h0B, 32'h0);
    chk("lb_0b", rsp_d, 32'hFFFFFFDE);
    xfer(1'b0, 3'b100, 32'h0B, 32'h0);
    chk("lbu_0b", rsp_d, 32'h000000DE);
    xfer(1'b0, 3'b101, 32'h0A, 32'h0);
    chk("lhu_0a", rsp_d, 32'h0000DEAD);
    xfer(1'b0, 3'b001, 32'h0A, 32'h0);
    chk("lh_0a", rsp_d, 32'hFFFFDEAD);

    // Unsupported store funct3
    xfer(1'b1, 3'b100, 32'h08, 32'hFFFFFFFF);
    chk("bad_st_lat", 32'(lat), 32'd1);
    chk("bad_st_err", 32'(rsp_e), 32'd1);
    chk("bad_st_nwe", 32'(nwe), 32'd0);
    chk("bad_st_mem", mem[2], 32'hDEAD7FEF);

    // Misaligned LW spanning words 1 and 2
    poke(5'd1, 32'h44332211);
    poke(5'd2, 32'h88776655);
    xfer(1'b0, 3'b010, 32'h07, 32'h0);
    chk("mis_lw_nwe", 32'(nwe), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lw_lat", 32'(lat), 32'd1);
    chk("mis_lw_err", 32'(rsp_e), 32'd1);
    chk("mis_lw_rdata", rsp_d, 32'h0);
    chk("mis_lw_addr", 32'(cyc_ad[1]), 32'd0);
`else
    chk("mis_lw_lat", 32'(lat), 32'd3);
    chk("mis_lw_err", 32'(rsp_e), 32'd0);
    chk("mis_lw_rdata", rsp_d, 32'h77665544);
    chk("mis_lw_addr0", 32'(cyc_ad[1]), 32'd1);
    chk("mis_lw_addr1", 32'(cyc_ad[2]), 32'd2);
`endif

    // Misaligned SH wrapping from word 31 to word 0
    poke(5'd31, 32'h11111111);
    poke(5'd0, 32'h22222222);
    xfer(1'b1, 3'b001, 32'h7F, 32'h0000A1B2);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("wrap_lat", 32'(lat), 32'd1);
    chk("wrap_err", 32'(rsp_e), 32'd1);
    chk("wrap_nwe", 32'(nwe), 32'd0);
    chk("wrap_mem31", mem[31], 32'h11111111);
    chk("wrap_mem0", mem[0], 32'h22222222);
`else
    chk("wrap_lat", 32'(lat), 32'd5);
    chk("wrap_rd0", 32'(cyc_ad[1]), 32'd31);
    chk("wrap_rd1", 32'(cyc_ad[2]), 32'd0);
    chk("wrap_wr0_addr", 32'(cyc_ad[3]), 32'd31);
    chk("wrap_wr0_data", cyc_wd[3], 32'hB2111111);
    chk("wrap_wr1_addr", 32'(cyc_ad[4]), 32'd0);
    chk("wrap_wr1_data", cyc_wd[4], 32'h222222A1);
    chk("wrap_nwe", 32'(nwe), 32'd2);
    chk("wrap_mem31", mem[31], 32'hB2111111);
    chk("wrap_mem0", mem[0], 32'h222222A1);
    chk("wrap_err", 32'(rsp_e), 32'd0);
`endif

    // Unsupported load funct3 with response backpressure
    resp_ready = 1'b0;
    xfer(1'b0, 3'b011, 32'h08, 32'h0);
    chk("bp_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_err", 32'(resp_err), 32'd1);
      chk("bp_resp_rdata", resp_rdata, 32'h0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_mem_we", 32'(mem_we), 32'd0);
      @(negedge CLK);
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_release_ready", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
